matmul_scheduler: RTL

MATMUL_SCHEDULER -- requirements
Module: matmul_scheduler

---
 rtl/matmul_scheduler_if.sv | 39 +++
 rtl/matmul_scheduler.sv | 120 ++++++++++++
 2 files changed

// File: rtl/matmul_scheduler_if.sv
// Handshake bundle for the matmul scheduler: two operand requesters, one
// result consumer and a busy status flag.
interface matmul_scheduler_if;
  logic        req0_valid;
  logic [8:0]  req0_a;
  logic [8:0]  req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [8:0]  req1_a;
  logic [8:0]  req1_b;
  logic        req1_ready;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_c;
  logic        out_id;
  logic        busy;

  // Requesters and consumer side
  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  out_valid,
    output out_ready,
    input  out_c, out_id, busy
  );

  // Scheduler side
  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output out_valid,
    input  out_ready,
    output out_c, out_id, busy
  );
endinterface

// File: rtl/matmul_scheduler.sv
// Two-requester scheduler for a binary 3x3 matrix multiply. One shared
// serial AND/accumulate unit produces one product term per cycle, so a
// product takes 27 MAC cycles before it is presented on the output.
//
// state | meaning
// IDLE  | waiting for a granted requester; ready follows grant
// MAC   | 27 serial steps over (i, j, k), row-major, k innermost
// DONE  | product held on out_c/out_id until the consumer takes it
module matmul_scheduler #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                clk,
  input  logic                rst,
  matmul_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam logic FIXED = (FIXED_PRIORITY != 0);

  state_t      state;
  state_t      state_next;
  logic [8:0]  a_q;
  logic [8:0]  b_q;
  logic        id_q;
  logic        last_grant;
  logic [1:0]  i_q;
  logic [1:0]  j_q;
  logic [1:0]  k_q;
  logic [1:0]  acc;
  logic [17:0] result;

  logic        grant0;
  logic        grant1;
  logic        take;
  logic        mac_last;
  logic [3:0]  a_idx;
  logic [3:0]  b_idx;
  logic [4:0]  c_lsb;
  logic        term;
  logic [1:0]  acc_sum;

  // Requester 0 wins a tie when fixed priority is selected or when
  // requester 1 was the last one served.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | FIXED | last_grant);
  assign grant1 = bus.req1_valid & ~grant0;
  assign take   = (state == IDLE) & (grant0 | grant1);

  assign bus.req0_ready = (state == IDLE) & grant0;
  assign bus.req1_ready = (state == IDLE) & grant1;
  assign bus.out_valid  = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.out_c      = result;
  assign bus.out_id     = id_q;

  assign a_idx    = 4'(i_q) * 4'd3 + 4'(k_q);
  assign b_idx    = 4'(k_q) * 4'd3 + 4'(j_q);
  assign c_lsb    = 5'(i_q) * 5'd6 + 5'(j_q) * 5'd2;
  assign term     = a_q[a_idx] & b_q[b_idx];
  assign acc_sum  = acc + {1'b0, term};
  assign mac_last = (i_q == 2'd2) & (j_q == 2'd2) & (k_q == 2'd2);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (take)          state_next = MAC;
      MAC:  if (mac_last)      state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Operand capture and the serial multiply-accumulate datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      acc        <= '0;
      result     <= '0;
    end else if (take) begin
      a_q    <= grant1 ? bus.req1_a : bus.req0_a;
      b_q    <= grant1 ? bus.req1_b : bus.req0_b;
      id_q   <= grant1;
      if (!FIXED) last_grant <= grant1;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      acc    <= '0;
      result <= '0;
    end else if (state == MAC) begin
      if (k_q == 2'd2) begin
        result[c_lsb +: 2] <= acc_sum;
        acc <= '0;
        k_q <= '0;
        if (j_q == 2'd2) begin
          j_q <= '0;
          i_q <= (i_q == 2'd2) ? 2'd0 : i_q + 2'd1;
        end else begin
          j_q <= j_q + 2'd1;
        end
      end else begin
        acc <= acc_sum;
        k_q <= k_q + 2'd1;
      end
    end
  end

endmodule
